// File: rtl/wvb_readout_arbiter.sv
// Round-robin readout scheduler for per-channel waveform buffers: grants one
// channel, presents its header, streams its samples, then retires the event.
module wvb_readout_arbiter #(
  parameter int unsigned P_N_CHAN     = 4,
  parameter int unsigned P_CHAN_WIDTH = 2,
  parameter int unsigned P_DATA_WIDTH = 22,
  parameter int unsigned P_ADR_WIDTH  = 12,
  parameter int unsigned P_HDR_WIDTH  = 80,
  parameter int unsigned P_RD_LAT     = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             enable,
  input  logic [P_N_CHAN-1:0]              chan_hdr_empty,
  input  logic [P_N_CHAN*P_HDR_WIDTH-1:0]  chan_hdr_data,
  input  logic [P_N_CHAN*P_DATA_WIDTH-1:0] chan_wvb_data,
  output logic [P_N_CHAN-1:0]              chan_hdr_rdreq,
  output logic [P_N_CHAN-1:0]              chan_wvb_rdreq,
  output logic [P_N_CHAN-1:0]              chan_wvb_rddone,
  input  logic                             dout_afull,
  output logic [P_HDR_WIDTH-1:0]           hdr_out,
  output logic [P_CHAN_WIDTH-1:0]          hdr_out_chan,
  output logic                             hdr_out_valid,
  output logic [P_DATA_WIDTH-1:0]          dout,
  output logic                             dout_valid,
  output logic                             dout_last,
  output logic                             busy,
  output logic [15:0]                      evt_cnt
);

  localparam int unsigned LEN_W = P_ADR_WIDTH + 1;

  typedef enum logic [2:0] {ARB, HDR, READ, DRAIN, DONE} state_t;

  // First non-empty channel at or after ptr, wrapping modulo P_N_CHAN.
  function automatic logic [P_CHAN_WIDTH-1:0] rr_pick(input logic [P_CHAN_WIDTH-1:0] ptr,
                                                       input logic [P_N_CHAN-1:0]     empty);
    logic [P_CHAN_WIDTH-1:0] pick;
    int unsigned             idx;
    pick = ptr;
    for (int i = int'(P_N_CHAN) - 1; i >= 0; i--) begin
      idx = 32'(ptr) + 32'(i);
      if (idx >= P_N_CHAN) idx = idx - P_N_CHAN;
      if (!empty[P_CHAN_WIDTH'(idx)]) pick = P_CHAN_WIDTH'(idx);
    end
    return pick;
  endfunction

  state_t                  state_q, state_d;
  logic [P_CHAN_WIDTH-1:0] chan_q, chan_d;
  logic [P_CHAN_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [P_HDR_WIDTH-1:0]  hdr_q, hdr_d;
  logic [LEN_W-1:0]        rem_q, rem_d;
  logic [15:0]             evt_cnt_q, evt_cnt_d;
  logic [P_RD_LAT-1:0]     vld_pipe_q, last_pipe_q;

  logic                    rd_c, last_c, retire_c;
  logic [P_CHAN_WIDTH-1:0] pick;
  logic [P_CHAN_WIDTH-1:0] chan_next;
  logic [P_HDR_WIDTH-1:0]  hdr_sel;
  logic [P_ADR_WIDTH-1:0]  span;
  logic [LEN_W-1:0]        len_sel;
  logic [P_N_CHAN-1:0]     chan_oh;

  assign pick      = rr_pick(rr_ptr_q, chan_hdr_empty);
  assign hdr_sel   = chan_hdr_data[32'(pick)*P_HDR_WIDTH +: P_HDR_WIDTH];
  // Span is taken modulo the buffer size so stop == start-1 means a full buffer.
  assign span      = hdr_sel[P_ADR_WIDTH-1:0] - hdr_sel[2*P_ADR_WIDTH-1:P_ADR_WIDTH];
  assign len_sel   = {1'b0, span} + LEN_W'(1);
  assign chan_oh   = P_N_CHAN'(1) << chan_q;
  assign chan_next = (32'(chan_q) == P_N_CHAN - 1) ? '0 : chan_q + P_CHAN_WIDTH'(1);

  always_comb begin
    state_d   = state_q;
    chan_d    = chan_q;
    hdr_d     = hdr_q;
    rem_d     = rem_q;
    rr_ptr_d  = rr_ptr_q;
    evt_cnt_d = evt_cnt_q;
    rd_c      = 1'b0;
    last_c    = 1'b0;
    retire_c  = 1'b0;
    unique case (state_q)
      ARB: begin
        if (enable && !(&chan_hdr_empty)) begin
          chan_d  = pick;
          hdr_d   = hdr_sel;
          rem_d   = len_sel;
          state_d = HDR;
        end
      end
      HDR: state_d = READ;
      READ: begin
        if (!dout_afull) begin
          rd_c  = 1'b1;
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            last_c  = 1'b1;
            state_d = DRAIN;
          end
        end
      end
      // Leave once only the output stage (the last word) remains in flight.
      DRAIN: begin
        if (P_RD_LAT'(vld_pipe_q << 1) == '0) state_d = DONE;
      end
      DONE: begin
        retire_c  = 1'b1;
        evt_cnt_d = evt_cnt_q + 16'd1;
        rr_ptr_d  = chan_next;
        state_d   = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB;
      chan_q      <= '0;
      rr_ptr_q    <= '0;
      hdr_q       <= '0;
      rem_q       <= '0;
      evt_cnt_q   <= '0;
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
    end else begin
      state_q     <= state_d;
      chan_q      <= chan_d;
      rr_ptr_q    <= rr_ptr_d;
      hdr_q       <= hdr_d;
      rem_q       <= rem_d;
      evt_cnt_q   <= evt_cnt_d;
      vld_pipe_q  <= P_RD_LAT'(vld_pipe_q << 1) | P_RD_LAT'(rd_c);
      last_pipe_q <= P_RD_LAT'(last_pipe_q << 1) | P_RD_LAT'(last_c);
    end
  end

  assign chan_wvb_rdreq  = rd_c     ? chan_oh : '0;
  assign chan_hdr_rdreq  = retire_c ? chan_oh : '0;
  assign chan_wvb_rddone = retire_c ? chan_oh : '0;
  assign hdr_out         = hdr_q;
  assign hdr_out_chan    = chan_q;
  assign hdr_out_valid   = (state_q == HDR);
  assign busy            = (state_q != ARB);
  assign evt_cnt         = evt_cnt_q;
  assign dout_valid      = vld_pipe_q[P_RD_LAT-1];
  assign dout_last       = last_pipe_q[P_RD_LAT-1];
  assign dout            = dout_valid ? chan_wvb_data[32'(chan_q)*P_DATA_WIDTH +: P_DATA_WIDTH] : '0;

endmodule

// File: tb/tb_wvb_readout_arbiter.sv
// Directed bench for wvb_readout_arbiter with header FIFO and waveform RAM models.
module tb_wvb_readout_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned CW  = 2;
  localparam int unsigned DW  = 22;
  localparam int unsigned AW  = 12;
  localparam int unsigned HW  = 80;
  localparam int unsigned LAT = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic [N-1:0]      chan_hdr_empty;
  logic [N*HW-1:0]   chan_hdr_data;
  logic [N*DW-1:0]   chan_wvb_data;
  logic [N-1:0]      chan_hdr_rdreq;
  logic [N-1:0]      chan_wvb_rdreq;
  logic [N-1:0]      chan_wvb_rddone;
  logic              dout_afull;
  logic [HW-1:0]     hdr_out;
  logic [CW-1:0]     hdr_out_chan;
  logic              hdr_out_valid;
  logic [DW-1:0]     dout;
  logic              dout_valid;
  logic              dout_last;
  logic              busy;
  logic [15:0]       evt_cnt;

  always #5 clk = ~clk;

  wvb_readout_arbiter #(
    .P_N_CHAN(N), .P_CHAN_WIDTH(CW), .P_DATA_WIDTH(DW),
    .P_ADR_WIDTH(AW), .P_HDR_WIDTH(HW), .P_RD_LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .chan_hdr_empty(chan_hdr_empty), .chan_hdr_data(chan_hdr_data),
    .chan_wvb_data(chan_wvb_data), .chan_hdr_rdreq(chan_hdr_rdreq),
    .chan_wvb_rdreq(chan_wvb_rdreq), .chan_wvb_rddone(chan_wvb_rddone),
    .dout_afull(dout_afull), .hdr_out(hdr_out), .hdr_out_chan(hdr_out_chan),
    .hdr_out_valid(hdr_out_valid), .dout(dout), .dout_valid(dout_valid),
    .dout_last(dout_last), .busy(busy), .evt_cnt(evt_cnt)
  );

  // Show-ahead header FIFOs and waveform RAMs with LAT-cycle read latency.
  logic [HW-1:0] fifo_mem [N][16];
  logic [3:0]    wp [N] = '{default: '0};
  logic [3:0]    rp [N] = '{default: '0};
  logic [AW-1:0] rptr [N] = '{default: '0};
  logic [DW-1:0] s0 [N] = '{default: '0};
  logic [DW-1:0] s1 [N] = '{default: '0};

  always_comb begin
    for (int c = 0; c < N; c++) begin
      chan_hdr_empty[c]          = (wp[c] == rp[c]);
      chan_hdr_data[c*HW +: HW]  = fifo_mem[c][rp[c]];
      chan_wvb_data[c*DW +: DW]  = s1[c];
    end
  end

  always @(posedge clk) begin
    for (int c = 0; c < N; c++) begin
      if (chan_hdr_rdreq[c]) rp[c] <= rp[c] + 4'd1;
      if (hdr_out_valid && hdr_out_chan == CW'(c)) rptr[c] <= hdr_out[2*AW-1:AW];
      else if (chan_wvb_rdreq[c]) begin
        s0[c]   <= {CW'(c), 8'h00, rptr[c]};
        rptr[c] <= rptr[c] + 12'd1;
      end
      s1[c] <= s0[c];
    end
  end

  // Output monitor: counts strobes and checks data order, one-hotness, backpressure.
  int cyc = 0, n_hdr = 0, n_rd = 0, n_dv = 0, n_last = 0, n_done = 0;
  int data_err = 0, oh_err = 0, bp_err = 0, afull_run = 0;
  int first_rd = -1, last_rd = 0, first_dv = -1, last_dv = 0, last_tag = 0;
  logic [CW-1:0] grants [64];
  logic [HW-1:0] last_hdr = '0;
  logic [AW-1:0] exp_ptr = '0;
  logic [CW-1:0] done_chan = '0;
  logic [N-1:0]  oh;
  assign oh = N'(1) << hdr_out_chan;

  always @(negedge clk) begin
    cyc       <= cyc + 1;
    afull_run <= dout_afull ? afull_run + 1 : 0;
    if (hdr_out_valid) begin
      grants[n_hdr[5:0]] <= hdr_out_chan;
      n_hdr    <= n_hdr + 1;
      last_hdr <= hdr_out;
      exp_ptr  <= hdr_out[2*AW-1:AW];
      first_rd <= -1;
      first_dv <= -1;
    end
    if (|chan_wvb_rdreq) begin
      n_rd    <= n_rd + 1;
      last_rd <= cyc;
      if (first_rd < 0) first_rd <= cyc;
    end
    if (dout_valid) begin
      n_dv    <= n_dv + 1;
      last_dv <= cyc;
      exp_ptr <= exp_ptr + 12'd1;
      if (first_dv < 0) first_dv <= cyc;
      if (dout !== {hdr_out_chan, 8'h00, exp_ptr}) data_err <= data_err + 1;
    end
    if (dout_last) begin
      n_last   <= n_last + 1;
      last_tag <= cyc;
    end
    if ((|chan_wvb_rdreq && dout_afull) || (dout_valid && dout_afull && afull_run >= int'(LAT)))
      bp_err <= bp_err + 1;
    if ((chan_wvb_rdreq != '0 && chan_wvb_rdreq != oh) || (chan_wvb_rddone != chan_hdr_rdreq) ||
        (chan_wvb_rddone != '0 && chan_wvb_rddone != oh) || (dout_last && !dout_valid))
      oh_err <= oh_err + 1;
    if (|chan_wvb_rddone) begin
      n_done    <= n_done + 1;
      done_chan <= hdr_out_chan;
    end
  end

  int n_assert = 0, n_fail = 0;
  int b_hdr, b_rd, b_dv, b_last, b_done, b_derr, b_oh, b_bp;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    b_hdr = n_hdr; b_rd = n_rd; b_dv = n_dv; b_last = n_last;
    b_done = n_done; b_derr = data_err; b_oh = oh_err; b_bp = bp_err;
  endtask

  task automatic push(input int c, input logic [HW-1:0] h);
    fifo_mem[c][wp[c]] = h;
    wp[c] = wp[c] + 4'd1;
  endtask

  function automatic logic [HW-1:0] mk_hdr(input logic [55:0] tag, input logic [11:0] st,
                                            input logic [11:0] sp);
    return {tag, st, sp};
  endfunction

  task automatic wait_done(input string tag, input int target, input int budget);
    int k;
    k = 0;
    while (n_done < target && k < budget) begin
      tick();
      k++;
    end
    chk(tag, 80'(n_done >= target), 80'(1));
    repeat (3) tick();
  endtask

  task automatic wait_rdreq(input string tag, input int budget);
    int k;
    k = 0;
    while (chan_wvb_rdreq == '0 && k < budget) begin
      tick();
      k++;
    end
    chk(tag, 80'(chan_wvb_rdreq != '0), 80'(1));
  endtask

  task automatic chk_clean(input string tag);
    chk({tag, "_data"}, 80'(data_err - b_derr), 80'(0));
    chk({tag, "_onehot"}, 80'(oh_err - b_oh), 80'(0));
  endtask

  logic [HW-1:0] h1;

  initial begin
    rst = 1'b1; enable = 1'b0; dout_afull = 1'b0;
    repeat (3) tick();
    // Reset state
    chk("rst_ctrl", 80'({busy, hdr_out_valid, chan_hdr_rdreq, chan_wvb_rdreq, chan_wvb_rddone,
                         dout_valid, dout_last}), 80'(0));
    chk("rst_hdr_out", 80'(hdr_out), 80'(0));
    chk("rst_evt_cnt", 80'(evt_cnt), 80'(0));
    rst = 1'b0;
    tick();

    // Single four-sample event on channel 1
    h1 = mk_hdr(56'hA5_1234_5678_9ABC, 12'h010, 12'h013);
    push(1, h1);
    snap();
    enable = 1'b1;
    wait_done("t1_timeout", b_done + 1, 100);
    chk("t1_grants", 80'(n_hdr - b_hdr), 80'(1));
    chk("t1_grant_chan", 80'(grants[6'(b_hdr)]), 80'(1));
    chk("t1_hdr_out", last_hdr, h1);
    chk("t1_rdreq", 80'(n_rd - b_rd), 80'(4));
    chk("t1_rdreq_consec", 80'(last_rd - first_rd), 80'(3));
    chk("t1_dv", 80'(n_dv - b_dv), 80'(4));
    chk("t1_dv_latency", 80'(first_dv - first_rd), 80'(LAT));
    chk("t1_last", 80'(n_last - b_last), 80'(1));
    chk("t1_last_pos", 80'(last_tag), 80'(last_dv));
    chk("t1_done_chan", 80'(done_chan), 80'(1));
    chk("t1_evt_cnt", 80'(evt_cnt), 80'(1));
    chk("t1_fifo_popped", 80'(chan_hdr_empty[1]), 80'(1));
    chk("t1_idle", 80'(busy), 80'(0));
    chk_clean("t1");

    // Enable low with non-empty FIFOs: no grants
    enable = 1'b0;
    for (int c = 0; c < N; c++) begin
      push(c, mk_hdr(56'(c), 12'(12'h0A0 + c), 12'(12'h0A0 + c)));
      push(c, mk_hdr(56'(c + 8), 12'(12'h0B0 + c), 12'(12'h0B0 + c)));
    end
    snap();
    repeat (6) tick();
    chk("en_low_busy", 80'(busy), 80'(0));
    chk("en_low_grants", 80'(n_hdr - b_hdr), 80'(0));

    // Round robin from rr_ptr=0 over two one-sample events per channel
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rr_rst_evt_cnt", 80'(evt_cnt), 80'(0));
    snap();
    enable = 1'b1;
    wait_done("rr_timeout", b_done + 8, 200);
    for (int i = 0; i < 8; i++) begin
      int idx;
      idx = b_hdr + i;
      chk($sformatf("rr_order_%0d", i), 80'(grants[idx[5:0]]), 80'(i % 4));
    end
    chk("rr_dv", 80'(n_dv - b_dv), 80'(8));
    chk("rr_last", 80'(n_last - b_last), 80'(8));
    chk("rr_evt_cnt", 80'(evt_cnt), 80'(8));
    chk_clean("rr");

    // Full-buffer wrap: stop == start-1 reads 4096 samples
    push(2, mk_hdr(56'h77, 12'h005, 12'h004));
    snap();
    wait_done("full_timeout", b_done + 1, 4400);
    chk("full_rdreq", 80'(n_rd - b_rd), 80'(4096));
    chk("full_dv", 80'(n_dv - b_dv), 80'(4096));
    chk("full_last", 80'(n_last - b_last), 80'(1));
    chk_clean("full");

    // start == stop == 0xFFF is a single sample
    push(3, mk_hdr(56'h78, 12'hFFF, 12'hFFF));
    snap();
    wait_done("one_timeout", b_done + 1, 100);
    chk("one_rdreq", 80'(n_rd - b_rd), 80'(1));
    chk("one_dv", 80'(n_dv - b_dv), 80'(1));
    chk("one_last", 80'(n_last - b_last), 80'(1));
    chk_clean("one");

    // Backpressure toggled every 3 cycles on a 64-sample event
    push(0, mk_hdr(56'h99, 12'h100, 12'h13F));
    snap();
    begin
      int k;
      k = 0;
      while (n_done < b_done + 1 && k < 1000) begin
        if (k % 3 == 0) dout_afull = ~dout_afull;
        tick();
        k++;
      end
    end
    dout_afull = 1'b0;
    chk("bp_timeout", 80'(n_done - b_done), 80'(1));
    repeat (3) tick();
    chk("bp_rdreq", 80'(n_rd - b_rd), 80'(64));
    chk("bp_dv", 80'(n_dv - b_dv), 80'(64));
    chk("bp_last", 80'(n_last - b_last), 80'(1));
    chk("bp_violations", 80'(bp_err - b_bp), 80'(0));
    chk_clean("bp");

    // Enable dropped mid-READ: event completes, no new grant
    push(1, mk_hdr(56'hC1, 12'h200, 12'h213));
    push(2, mk_hdr(56'hC2, 12'h020, 12'h027));
    snap();
    enable = 1'b1;
    wait_rdreq("en_mid_rdreq", 50);
    enable = 1'b0;
    repeat (60) tick();
    chk("en_mid_done", 80'(n_done - b_done), 80'(1));
    chk("en_mid_grants", 80'(n_hdr - b_hdr), 80'(1));
    chk("en_mid_dv", 80'(n_dv - b_dv), 80'(20));
    chk("en_mid_idle", 80'(busy), 80'(0));
    chk("en_mid_ch2_pending", 80'(chan_hdr_empty[2]), 80'(0));
    chk_clean("en_mid");

    // Reset mid-READ abandons the event; header is re-read afterwards
    snap();
    enable = 1'b1;
    wait_rdreq("rst_mid_rdreq", 50);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_ctrl", 80'({busy, hdr_out_valid, chan_hdr_rdreq, chan_wvb_rdreq, chan_wvb_rddone,
                             dout_valid, dout_last}), 80'(0));
    chk("rst_mid_dout", 80'(dout), 80'(0));
    chk("rst_mid_hdr_out", 80'(hdr_out), 80'(0));
    chk("rst_mid_evt_cnt", 80'(evt_cnt), 80'(0));
    tick();
    chk("rst_mid_no_rddone", 80'(n_done - b_done), 80'(0));
    chk("rst_mid_not_popped", 80'(chan_hdr_empty[2]), 80'(0));
    rst = 1'b0;
    snap();
    wait_done("rst_rerun_timeout", b_done + 1, 100);
    chk("rst_rerun_chan", 80'(grants[6'(b_hdr)]), 80'(2));
    chk("rst_rerun_dv", 80'(n_dv - b_dv), 80'(8));
    chk("rst_rerun_last", 80'(n_last - b_last), 80'(1));
    chk("rst_rerun_evt_cnt", 80'(evt_cnt), 80'(1));
    chk("rst_rerun_popped", 80'(chan_hdr_empty[2]), 80'(1));
    chk_clean("rst_rerun");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
